// File: rtl/mux_sel_sequencer.sv
// mux_sel_sequencer
// Upstream controller for a 4-to-1 mux. Steps the registered select through
// the channels, holds each one for DWELL enabled cycles, then captures the mux
// output as a tagged sample with a one-cycle valid strobe. Runs either a single
// 4-channel sweep (ending with a one-cycle done pulse) or continuous
// round-robin scanning.
//
// Optional feature macro: SEQ_CHAN_MASK_EN
//   When defined, adds input chan_mask[3:0]. A set bit skips that channel.
//   The mask is latched at start. An all-ones mask makes start a no-op.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   start        in   begin a sweep (only looked at in IDLE)
//   stop         in   abort the sweep, highest priority
//   en           in   dwell-count enable; low pauses the sequencer
//   cont         in   1 = continuous scanning, 0 = single sweep (latched at start)
//   chan_mask    in   [3:0] channel skip mask (SEQ_CHAN_MASK_EN only)
//   ou1          in   [Width-1:0] mux output, combinational from sel
//   sel          out  [1:0] mux select, registered
//   sample_data  out  [Width-1:0] captured ou1
//   sample_ch    out  [1:0] channel that sample_data came from
//   sample_valid out  one-cycle strobe, sample fields valid
//   busy         out  high while dwelling
//   done         out  one-cycle pulse at the end of a single sweep
module mux_sel_sequencer #(
  parameter int Width = 4,
  parameter int DWELL = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  input  logic             cont,
`ifdef SEQ_CHAN_MASK_EN
  input  logic [3:0]       chan_mask,
`endif
  input  logic [Width-1:0] ou1,
  output logic [1:0]       sel,
  output logic [Width-1:0] sample_data,
  output logic [1:0]       sample_ch,
  output logic             sample_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = ($clog2(DWELL + 1) < 1) ? 1 : $clog2(DWELL + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(DWELL - 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DWELL = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic [1:0]       sel_r, sel_s;
  logic             cont_r, cont_s;
  logic [3:0]       mask_r, mask_s;
  logic [Width-1:0] sdata_r, sdata_s;
  logic [1:0]       sch_r, sch_s;
  logic             svalid_r, svalid_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic [3:0]       start_mask_s;

`ifdef SEQ_CHAN_MASK_EN
  assign start_mask_s = chan_mask;
`else
  assign start_mask_s = 4'b0000;
`endif

  // Lowest channel not skipped by the mask.
  function automatic logic [1:0] first_ch(input logic [3:0] m);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!m[i]) r = 2'(i);
      else       r = r;
    end
    return r;
  endfunction

  // Highest channel not skipped by the mask: the last capture of a single sweep.
  function automatic logic [1:0] last_ch(input logic [3:0] m);
    logic [1:0] r;
    r = 2'd3;
    for (int i = 0; i <= 3; i++) begin
      if (!m[i]) r = 2'(i);
      else       r = r;
    end
    return r;
  endfunction

  // Next unmasked channel after cur, wrapping; falls back to cur itself when
  // it is the only channel enabled (k = 4 wraps back onto cur).
  function automatic logic [1:0] next_ch(input logic [3:0] m, input logic [1:0] cur);
    logic [1:0] r;
    logic [1:0] idx;
    r = cur + 2'd1;
    for (int k = 4; k >= 1; k--) begin
      idx = cur + 2'(k);
      if (!m[idx]) r = idx;
      else         r = r;
    end
    return r;
  endfunction

  // Next-state and next-output logic; every output is computed here and registered below.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    sel_s    = sel_r;
    cont_s   = cont_r;
    mask_s   = mask_r;
    sdata_s  = sdata_r;
    sch_s    = sch_r;
    svalid_s = 1'b0;
    done_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start && !stop && (start_mask_s != 4'b1111)) begin
          state_s = ST_DWELL;
          sel_s   = first_ch(start_mask_s);
          cnt_s   = CNT_LOAD;
          cont_s  = cont;
          mask_s  = start_mask_s;
        end else begin
          sel_s   = 2'd0;
        end
      end
      ST_DWELL: begin
        if (stop) begin
          state_s = ST_IDLE;
          sel_s   = 2'd0;
          cnt_s   = CNT_ZERO;
        end else if (!en) begin
          state_s = ST_DWELL;
        end else if (cnt_r != CNT_ZERO) begin
          cnt_s = cnt_r - CW'(1);
        end else begin
          sdata_s  = ou1;
          sch_s    = sel_r;
          svalid_s = 1'b1;
          if ((sel_r == last_ch(mask_r)) && !cont_r) begin
            // done is raised together with the entry into DONE so it
            // lines up with the final sample strobe.
            state_s = ST_DONE;
            sel_s   = 2'd0;
            done_s  = 1'b1;
          end else begin
            sel_s = next_ch(mask_r, sel_r);
            cnt_s = CNT_LOAD;
          end
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
        sel_s   = 2'd0;
        cnt_s   = CNT_ZERO;
      end
    endcase
    busy_s = (state_s == ST_DWELL);
  end

  // State and registered-output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      cnt_r    <= CNT_ZERO;
      sel_r    <= 2'd0;
      cont_r   <= 1'b0;
      mask_r   <= 4'b0000;
      sdata_r  <= {Width{1'b0}};
      sch_r    <= 2'd0;
      svalid_r <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      sel_r    <= sel_s;
      cont_r   <= cont_s;
      mask_r   <= mask_s;
      sdata_r  <= sdata_s;
      sch_r    <= sch_s;
      svalid_r <= svalid_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
    end
  end

  assign sel          = sel_r;
  assign sample_data  = sdata_r;
  assign sample_ch    = sch_r;
  assign sample_valid = svalid_r;
  assign busy         = busy_r;
  assign done         = done_r;

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Self-checking bench for mux_sel_sequencer (Width=4, DWELL=20) driving a real
// 4-to-1 mux with inputs 1,2,3,4. Expected samples and done pulses are pushed
// into queues when a sweep is started and popped when the DUT strobes.
module tb_mux_sel_sequencer;

  localparam int W  = 4;
  localparam int DW = 20;

  typedef struct {
    int         edge_no;
    logic [1:0] ch;
    logic [3:0] data;
  } samp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         en = 1'b1;
  logic         cont = 1'b0;
  logic [W-1:0] ou1;
  logic [1:0]   sel;
  logic [W-1:0] sample_data;
  logic [1:0]   sample_ch;
  logic         sample_valid;
  logic         busy;
  logic         done;
`ifdef SEQ_CHAN_MASK_EN
  logic [3:0]   chan_mask = 4'b0000;
`endif

  int    edge_cnt = 0;
  int    total_cnt = 0;
  int    pass_cnt = 0;
  samp_t samp_q[$];
  int    done_q[$];

  mux_sel_sequencer #(.Width(W), .DWELL(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .en(en), .cont(cont),
`ifdef SEQ_CHAN_MASK_EN
    .chan_mask(chan_mask),
`endif
    .ou1(ou1), .sel(sel), .sample_data(sample_data), .sample_ch(sample_ch),
    .sample_valid(sample_valid), .busy(busy), .done(done)
  );

  // Real mux: in1..in4 = 1..4
  always_comb begin
    case (sel)
      2'd0:    ou1 = 4'd1;
      2'd1:    ou1 = 4'd2;
      2'd2:    ou1 = 4'd3;
      2'd3:    ou1 = 4'd4;
      default: ou1 = 4'd0;
    endcase
  end

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_cnt);
  endtask

  // Scoreboard: every strobe must match the head of its queue, at the right edge.
  always @(negedge clk) begin
    if (sample_valid === 1'b1) begin
      if (samp_q.size() == 0) begin
        check_eq("spurious_sample", 32'd1, 32'd0);
      end else begin
        samp_t e;
        e = samp_q.pop_front();
        check_eq("sample_edge", edge_cnt, e.edge_no);
        check_eq("sample_ch", {30'd0, sample_ch}, {30'd0, e.ch});
        check_eq("sample_data", {28'd0, sample_data}, {28'd0, e.data});
      end
    end
    if (done === 1'b1) begin
      if (done_q.size() == 0) check_eq("spurious_done", 32'd1, 32'd0);
      else check_eq("done_edge", edge_cnt, done_q.pop_front());
    end
  end

  task automatic wait_edge(input int target);
    while (edge_cnt < target) @(negedge clk);
  endtask

  // Pulse start for one cycle; e0 is the edge that samples it.
  task automatic do_start(input logic c, output int e0);
    @(negedge clk);
    start = 1'b1;
    cont  = c;
    e0    = edge_cnt + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic push_samp(input int e, input int ch);
    samp_t s;
    s.edge_no = e;
    s.ch      = 2'(ch);
    s.data    = 4'(ch + 1);
    samp_q.push_back(s);
  endtask

  task automatic check_drained(input string tag);
    check_eq({tag, "_samples_left"}, samp_q.size(), 32'd0);
    check_eq({tag, "_done_left"}, done_q.size(), 32'd0);
  endtask

  task automatic single_sweep(input string tag);
    int e0;
    @(negedge clk);
    e0 = edge_cnt + 1;
    for (int k = 0; k < 4; k++) push_samp(e0 + DW * (k + 1), k);
    done_q.push_back(e0 + 4 * DW);
    start = 1'b1;
    cont  = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check_eq({tag, "_busy_start"}, {31'd0, busy}, 32'd1);
    check_eq({tag, "_sel_ch0"}, {30'd0, sel}, 32'd0);
    wait_edge(e0 + 10);
    start = 1'b1;                        // ignored outside IDLE
    @(negedge clk);
    start = 1'b0;
    wait_edge(e0 + 30);
    check_eq({tag, "_sel_ch1"}, {30'd0, sel}, 32'd1);
    wait_edge(e0 + 4 * DW - 1);
    check_eq({tag, "_busy_last"}, {31'd0, busy}, 32'd1);
    wait_edge(e0 + 4 * DW + 1);
    check_eq({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
    check_eq({tag, "_sel_after"}, {30'd0, sel}, 32'd0);
    repeat (5) @(negedge clk);
    check_drained(tag);
  endtask

  initial begin
    int e0;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_sel", {30'd0, sel}, 32'd0);
    check_eq("rst_valid", {31'd0, sample_valid}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // start with stop high is suppressed
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    check_eq("start_stop_idle", {31'd0, busy}, 32'd0);

    // Scenario 1: single sweep
    single_sweep("single");

    // Scenario 2: continuous, five samples, then stop before the sixth
    @(negedge clk);
    e0 = edge_cnt + 1;
    for (int k = 0; k < 5; k++) push_samp(e0 + DW * (k + 1), k % 4);
    start = 1'b1;
    cont  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cont  = 1'b0;
    wait_edge(e0 + 4 * DW + 1);
    check_eq("cont_wrap_sel", {30'd0, sel}, 32'd0);
    check_eq("cont_busy", {31'd0, busy}, 32'd1);
    wait_edge(e0 + 105);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check_eq("cont_stop_busy", {31'd0, busy}, 32'd0);
    repeat (30) @(negedge clk);
    check_drained("cont");

    // Scenario 3: stop while ch1 dwells
    do_start(1'b0, e0);
    push_samp(e0 + DW, 0);
    wait_edge(e0 + 29);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check_eq("stop_busy", {31'd0, busy}, 32'd0);
    check_eq("stop_sel", {30'd0, sel}, 32'd0);
    repeat (80) @(negedge clk);
    check_drained("stop");

    // Scenario 4: en low for ten edges during ch0 shifts everything by ten
    @(negedge clk);
    e0 = edge_cnt + 1;
    for (int k = 0; k < 4; k++) push_samp(e0 + 10 + DW * (k + 1), k);
    done_q.push_back(e0 + 10 + 4 * DW);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_edge(e0 + 4);
    en = 1'b0;
    wait_edge(e0 + 14);
    en = 1'b1;
    check_eq("pause_busy", {31'd0, busy}, 32'd1);
    wait_edge(e0 + 10 + 4 * DW + 5);
    check_drained("pause");

    // Scenario 5: async reset mid-sweep, then a clean sweep
    do_start(1'b0, e0);
    push_samp(e0 + DW, 0);
    push_samp(e0 + 2 * DW, 1);
    wait_edge(e0 + 49);
    rst_n = 1'b0;
    #1;
    check_eq("arst_busy", {31'd0, busy}, 32'd0);
    check_eq("arst_sel", {30'd0, sel}, 32'd0);
    check_eq("arst_data", {28'd0, sample_data}, 32'd0);
    check_eq("arst_ch", {30'd0, sample_ch}, 32'd0);
    check_eq("arst_valid", {31'd0, sample_valid}, 32'd0);
    check_eq("arst_done", {31'd0, done}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_drained("arst");
    single_sweep("after_rst");

`ifdef SEQ_CHAN_MASK_EN
    // Masked sweep: only ch1 and ch3
    chan_mask = 4'b0101;
    @(negedge clk);
    e0 = edge_cnt + 1;
    push_samp(e0 + DW, 1);
    push_samp(e0 + 2 * DW, 3);
    done_q.push_back(e0 + 2 * DW);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("mask_first_sel", {30'd0, sel}, 32'd1);
    wait_edge(e0 + 2 * DW + 5);
    check_drained("mask");
    chan_mask = 4'b1111;
    do_start(1'b0, e0);
    check_eq("mask_all_busy", {31'd0, busy}, 32'd0);
    chan_mask = 4'b0000;
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
